tia_playfield_serializer: RTL and testbench
===========================================

// Module: tia_playfield_serializer
// PURPOSE
//  Parametrised playfield generator: holds the playfield bitmap written over the register bus
//  and serialises it onto one pixel line, left half then right half, each bit held CLKS_PER_BIT clocks.
//  Right half repeats or mirrors the left half per reflect. Sits between the register decode and the
//  colour/priority mux; replaces the fixed 20-bit two-phase playfield chain with a single-clock design.
// PARAMETERS
//  PF_BITS       20  playfield bits per half line; 1..64
//  CLKS_PER_BIT   4  clocks each bit is displayed; >=1
//  TIA_ORDER      1  1: PF0[7:4] LSB-first, PF1[7:0] MSB-first, PF2[7:0] LSB-first (PF_BITS must be 20)
//                    0: linear; register k holds display bits 8k..8k+7, LSB-first
//  NUM_REGS       3  playfield registers; NUM_REGS*8 >= PF_BITS
// PORTS
//  clock       in   1  sole clock, rising edge
//  reset       in   1  synchronous, active-high
//  line_start  in   1  one-clock pulse at end of horizontal blank; starts left half
//  reflect     in   1  mirror mode; sampled on the clock the right half begins
//  wr_en       in   1  register write strobe
//  wr_addr     in   $clog2(NUM_REGS)  register select (PF0=0, PF1=1, PF2=2 ...)
//  wr_data     in   8  write data
//  pf          out  1  serial playfield pixel (registered)
//  pf_active   out  1  high while a half line is being serialised
//  bit_index   out  $clog2(PF_BITS)  display bit index currently on pf (0 when idle)
// BEHAVIOUR
//  - Reset: state IDLE, all registers 0, pf=0, pf_active=0, bit_index=0, sub-counter 0. Reset wins over
//    every other input the same clock.
//  - States: IDLE -> LEFT on line_start; LEFT -> RIGHT after PF_BITS*CLKS_PER_BIT clocks (no gap);
//    RIGHT -> IDLE after PF_BITS*CLKS_PER_BIT clocks. line_start in LEFT/RIGHT restarts LEFT at bit 0.
//  - Sub-counter 0..CLKS_PER_BIT-1; bit index advances when it wraps. LEFT and RIGHT-repeat count
//    0..PF_BITS-1; RIGHT-reflect counts PF_BITS-1..0. Reflect latched at LEFT->RIGHT; changes
//    mid-half have no effect until the next half boundary.
//  - pf/pf_active/bit_index are registered: on the edge that samples line_start, pf <= bitmap[0].
//    pf is reloaded from the bitmap every clock, so a write at edge T is visible on pf from edge T+1
//    even mid-bit (writes are not deferred to bit boundaries). Same-edge write: old value used.
//  - Total active window 2*PF_BITS*CLKS_PER_BIT clocks; in IDLE pf=0 regardless of bitmap.
//  - Writes: wr_addr >= NUM_REGS ignored. Unused bits (PF0[3:0] in TIA_ORDER, bits beyond PF_BITS in
//    linear) stored but never displayed. Writes accepted in every state including IDLE.
//  - Counter widths sized for PF_BITS/CLKS_PER_BIT maxima; no wrap past PF_BITS-1 or below 0.
// STRUCTURE
//  - Package tia_playfield_pkg: state enum (IDLE, LEFT, RIGHT), register address constants
//    PF0/PF1/PF2, TIA display-order bit map function.
//  - Sub-module tia_playfield_bitmap: register file + order mapping, flat PF_BITS vector out.
//  - Top: state machine, sub/bit counters, reflect latch, output register.
// TESTING  (PF_BITS=20, CLKS_PER_BIT=4, TIA_ORDER=1)
//  - Reset mid-LEFT with PF regs nonzero -> next clock pf=0, pf_active=0, regs read back 0 on replay.
//  - PF0=0x10, PF1=PF2=0, reflect=0, line_start -> pf=1 clocks 0-3 and 80-83 of window; 0 elsewhere;
//    pf_active high exactly 160 clocks.
//  - PF2=0x80, reflect=1 -> pf=1 clocks 76-79 and 80-83 (centre double-width); reflect=0 -> 76-79,156-159.
//  - PF1=0x80 -> bit 4 lit (clocks 16-19); PF1=0x01 -> bit 11 (clocks 44-47): MSB-first order check.
//  - Write PF0=0x10 at clock 2 of bit 0 -> pf goes 1 at clock 3 only; toggle reflect at clock 40 -> no effect
//    on right-half direction unless held at clock 80.
//  - line_start again at clock 100 -> LEFT restarts, bit_index=0, window ends 160 clocks later;
//    write to wr_addr=3 -> no register changes.

Source files
------------

// File: rtl/tia_playfield_pkg.sv
// Shared types and constants for the playfield serializer.
package tia_playfield_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_t;

    localparam int PF0 = 0;
    localparam int PF1 = 1;
    localparam int PF2 = 2;

    // Maps a display bit (0 = leftmost) to its position in the flat
    // {PF2, PF1, PF0} register vector for the classic 20-bit layout:
    // PF0[7:4] LSB-first, PF1[7:0] MSB-first, PF2[7:0] LSB-first.
    function automatic int tia_src_bit(input int d);
        if (d < 4)
            return d + 4;
        else if (d < 12)
            return 19 - d;
        else
            return d + 4;
    endfunction

endpackage

// File: rtl/tia_playfield_bitmap.sv
// Playfield register file and display-order mapping to a flat bitmap.
module tia_playfield_bitmap
    import tia_playfield_pkg::*;
#(
    parameter int PF_BITS   = 20,
    parameter int TIA_ORDER = 1,
    parameter int NUM_REGS  = 3,
    parameter int AW        = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [7:0]         wr_data,
    output logic [PF_BITS-1:0] bitmap
);

    logic [NUM_REGS*8-1:0] regs;

    // Register writes; addresses without a matching register fall through untouched.
    always_ff @(posedge clock) begin
        if (reset) begin
            regs <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (wr_en && (wr_addr == AW'(r)))
                    regs[r*8 +: 8] <= wr_data;
            end
        end
    end

    for (genvar d = 0; d < PF_BITS; d++) begin : g_map
        localparam int SRC = (TIA_ORDER != 0) ? tia_src_bit(d) : d;
        assign bitmap[d] = regs[SRC];
    end

    // Some stored bits are never displayed (PF0[3:0], or tail bits in linear mode).
    logic unused_regs;
    assign unused_regs = ^regs;

endmodule

// File: rtl/tia_playfield_serializer.sv
// Playfield serializer: shifts the bitmap out left half then right half
// (repeat or mirror), each bit held CLKS_PER_BIT clocks.
//
//  state | meaning
//  IDLE  | no half line in progress, pf forced low
//  LEFT  | left half, bits 0..PF_BITS-1
//  RIGHT | right half, ascending (repeat) or descending (reflect)
module tia_playfield_serializer
    import tia_playfield_pkg::*;
#(
    parameter  int PF_BITS      = 20,
    parameter  int CLKS_PER_BIT = 4,
    parameter  int TIA_ORDER    = 1,
    parameter  int NUM_REGS     = 3,
    localparam int AW           = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    localparam int BW           = (PF_BITS > 1) ? $clog2(PF_BITS) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          line_start,
    input  logic          reflect,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    output logic          pf,
    output logic          pf_active,
    output logic [BW-1:0] bit_index
);

    localparam int SW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [SW-1:0] SUB_LAST = SW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(PF_BITS - 1);

    state_t              state, state_n;
    logic [SW-1:0]       sub_cnt, sub_n;
    logic [BW-1:0]       bit_cnt, bit_n;
    logic                refl, refl_n;
    logic [PF_BITS-1:0]  bitmap;

    tia_playfield_bitmap #(
        .PF_BITS   (PF_BITS),
        .TIA_ORDER (TIA_ORDER),
        .NUM_REGS  (NUM_REGS),
        .AW        (AW)
    ) u_bitmap (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .bitmap  (bitmap)
    );

    // Next state, sub/bit counters and reflect latch.
    always_comb begin
        state_n = state;
        sub_n   = sub_cnt;
        bit_n   = bit_cnt;
        refl_n  = refl;
        if (line_start) begin
            state_n = LEFT;
            sub_n   = '0;
            bit_n   = '0;
        end else begin
            case (state)
                LEFT: begin
                    if (sub_cnt == SUB_LAST) begin
                        sub_n = '0;
                        if (bit_cnt == BIT_LAST) begin
                            state_n = RIGHT;
                            refl_n  = reflect;
                            bit_n   = reflect ? BIT_LAST : '0;
                        end else begin
                            bit_n = bit_cnt + 1'b1;
                        end
                    end else begin
                        sub_n = sub_cnt + 1'b1;
                    end
                end
                RIGHT: begin
                    if (sub_cnt == SUB_LAST) begin
                        sub_n = '0;
                        if (refl ? (bit_cnt == '0) : (bit_cnt == BIT_LAST)) begin
                            state_n = IDLE;
                            bit_n   = '0;
                        end else begin
                            bit_n = refl ? (bit_cnt - 1'b1) : (bit_cnt + 1'b1);
                        end
                    end else begin
                        sub_n = sub_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // State and output registers; pf is reloaded from the live bitmap every clock.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            sub_cnt   <= '0;
            bit_cnt   <= '0;
            refl      <= 1'b0;
            pf        <= 1'b0;
            pf_active <= 1'b0;
            bit_index <= '0;
        end else begin
            state     <= state_n;
            sub_cnt   <= sub_n;
            bit_cnt   <= bit_n;
            refl      <= refl_n;
            pf        <= (state_n != IDLE) && bitmap[bit_n];
            pf_active <= (state_n != IDLE);
            bit_index <= (state_n != IDLE) ? bit_n : '0;
        end
    end

endmodule

// File: tb/tb_tia_playfield_serializer.sv
// Directed bench for the playfield serializer (PF_BITS=20, CLKS_PER_BIT=4, TIA order).
module tb_tia_playfield_serializer;
    import tia_playfield_pkg::*;

    localparam int NCLK = 280;

    logic       clock = 1'b0;
    logic       reset, line_start, reflect, wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       pf, pf_active;
    logic [4:0] bit_index;

    int n_chk  = 0;
    int n_pass = 0;

    logic [NCLK-1:0] pf_log, act_log;
    logic [4:0]      bi_log [NCLK];

    int         wr_at, wr_a, ls_at, rf_lo, rf_hi;
    logic [7:0] wr_d;
    logic       rf_base;

    tia_playfield_serializer #(
        .PF_BITS      (20),
        .CLKS_PER_BIT (4),
        .TIA_ORDER    (1),
        .NUM_REGS     (3)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .line_start (line_start),
        .reflect    (reflect),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .pf         (pf),
        .pf_active  (pf_active),
        .bit_index  (bit_index)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [NCLK-1:0] got, input logic [NCLK-1:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [NCLK-1:0] span(input int a, input int b);
        logic [NCLK-1:0] v;
        v = '0;
        for (int i = a; i <= b; i++) v[i] = 1'b1;
        return v;
    endfunction

    task automatic wr_reg(input int a, input logic [7:0] d);
        wr_addr = 2'(a);
        wr_data = d;
        wr_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
    endtask

    // Inputs sampled at window edge e (edge 0 samples line_start).
    task automatic drive(input int e);
        line_start = (e == 0) || (e == ls_at);
        wr_en      = (e == wr_at);
        wr_addr    = 2'(wr_a);
        wr_data    = wr_d;
        reflect    = (e >= rf_lo && e <= rf_hi) ? ~rf_base : rf_base;
    endtask

    task automatic run_window();
        drive(0);
        tick();
        for (int k = 0; k < NCLK; k++) begin
            pf_log[k]  = pf;
            act_log[k] = pf_active;
            bi_log[k]  = bit_index;
            drive(k + 1);
            tick();
        end
        line_start = 1'b0;
        wr_en      = 1'b0;
        wr_at = -1; ls_at = -1; rf_lo = -1; rf_hi = -2;
    endtask

    initial begin
        reset = 1'b1; line_start = 1'b0; reflect = 1'b0; wr_en = 1'b0;
        wr_addr = '0; wr_data = '0;
        wr_at = -1; wr_a = 0; wr_d = '0; ls_at = -1; rf_lo = -1; rf_hi = -2; rf_base = 1'b0;
        tick(); tick();
        check("rst_pf", NCLK'(pf), '0);
        check("rst_active", NCLK'(pf_active), '0);
        check("rst_bit_index", NCLK'(bit_index), '0);
        reset = 1'b0;
        tick();

        // PF0 bit 4 -> display bit 0, repeat
        wr_reg(PF0, 8'h10);
        run_window();
        check("pf0_repeat", pf_log, span(0, 3) | span(80, 83));
        check("active_160", act_log, span(0, 159));
        check("bi_clk44", NCLK'(bi_log[44]), NCLK'(11));
        check("bi_clk80_rep", NCLK'(bi_log[80]), NCLK'(0));
        check("bi_clk159_rep", NCLK'(bi_log[159]), NCLK'(19));
        check("bi_idle", NCLK'(bi_log[170]), NCLK'(0));

        // PF2 bit 7 -> display bit 19, reflect: double-width centre
        wr_reg(PF0, 8'h00);
        wr_reg(PF2, 8'h80);
        rf_base = 1'b1;
        run_window();
        check("pf2_reflect", pf_log, span(76, 83));
        check("active_refl", act_log, span(0, 159));
        check("bi_clk80_refl", NCLK'(bi_log[80]), NCLK'(19));
        check("bi_clk159_refl", NCLK'(bi_log[159]), NCLK'(0));

        rf_base = 1'b0;
        run_window();
        check("pf2_repeat", pf_log, span(76, 79) | span(156, 159));

        // PF1 is MSB-first
        wr_reg(PF2, 8'h00);
        wr_reg(PF1, 8'h80);
        run_window();
        check("pf1_msb", pf_log, span(16, 19) | span(96, 99));
        wr_reg(PF1, 8'h01);
        run_window();
        check("pf1_lsb", pf_log, span(44, 47) | span(124, 127));

        // Mid-bit write at edge 2 is visible from clock 3
        wr_reg(PF1, 8'h00);
        wr_at = 2; wr_a = PF0; wr_d = 8'h10;
        run_window();
        check("midbit_write", pf_log, span(3, 3) | span(80, 83));

        // Reflect changes away from the half boundary are ignored
        wr_reg(PF0, 8'h00);
        wr_reg(PF2, 8'h80);
        rf_base = 1'b0; rf_lo = 38; rf_hi = 42;
        run_window();
        check("refl_pulse_mid", pf_log, span(76, 79) | span(156, 159));
        rf_base = 1'b1; rf_lo = 38; rf_hi = 42;
        run_window();
        check("refl_drop_mid", pf_log, span(76, 83));
        rf_base = 1'b0; rf_lo = 80; rf_hi = 80;
        run_window();
        check("refl_at_80", pf_log, span(76, 83));
        rf_base = 1'b0; rf_lo = 79; rf_hi = 79;
        run_window();
        check("refl_at_79", pf_log, span(76, 79) | span(156, 159));

        // Restart at clock 100, plus an ignored write to address 3
        wr_reg(PF2, 8'h00);
        wr_reg(PF0, 8'h10);
        rf_base = 1'b0;
        ls_at = 100; wr_at = 10; wr_a = 3; wr_d = 8'hFF;
        run_window();
        check("restart_pf", pf_log, span(0, 3) | span(80, 83) | span(100, 103) | span(180, 183));
        check("restart_active", act_log, span(0, 259));
        check("bi_clk99", NCLK'(bi_log[99]), NCLK'(4));
        check("bi_clk100", NCLK'(bi_log[100]), NCLK'(0));

        // Reset mid-LEFT wins over line_start and a write on the same clock
        wr_reg(PF1, 8'hFF);
        wr_reg(PF2, 8'hFF);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        repeat (19) tick();
        check("pre_reset_pf", NCLK'(pf), NCLK'(1));
        reset = 1'b1; line_start = 1'b1;
        wr_en = 1'b1; wr_addr = 2'(PF1); wr_data = 8'h55;
        tick();
        check("reset_pf", NCLK'(pf), '0);
        check("reset_active", NCLK'(pf_active), '0);
        check("reset_bit_index", NCLK'(bit_index), '0);
        reset = 1'b0; line_start = 1'b0; wr_en = 1'b0;
        tick();
        run_window();
        check("reset_regs_clear", pf_log, '0);
        check("reset_replay_active", act_log, span(0, 159));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
